// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the synchronous FIFO controller and its storage array.
// Pointer types are declared per instance so each FIFO can pick its own address width.
package fifo_pkg;

    localparam int unsigned FIFO_ADDR_WIDTH_DEFAULT = 32'd4;
    localparam int unsigned FIFO_DATA_WIDTH_DEFAULT = 32'd16;

    function automatic int unsigned fifo_depth(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

    // One extra bit beyond the RAM address distinguishes full from empty.
    function automatic int unsigned fifo_ptr_width(input int unsigned addr_width);
        return addr_width + 32'd1;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Storage array for the FIFO: synchronous write port, combinational read port.
// Contents are never reset; the controller relies only on its pointers.
module sync_fifo_ram
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH_DEFAULT,
    parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH_DEFAULT
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH-1:0] addr_out,
    output logic [DATA_WIDTH-1:0] data_out
);

    localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem_r [0:DEPTH-1];

    // Write port; writes are blocked while the controller is held in reset.
    always_ff @(posedge aclk) begin
        if (aresetn && wr_en) begin
            mem_r[addr_in] <= data_in;
        end
    end

    assign data_out = mem_r[addr_out];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// First-word-fall-through FIFO controller for the Chien-search datapath.
// All status outputs decode from the two registered wrap-bit pointers only.
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = FIFO_ADDR_WIDTH_DEFAULT,
    parameter int unsigned DATA_WIDTH   = FIFO_DATA_WIDTH_DEFAULT,
    parameter int unsigned AFULL_THRESH = fifo_depth(ADDR_WIDTH) - 32'd2
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  flush,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  afull
);

    localparam int unsigned PTR_W = fifo_ptr_width(ADDR_WIDTH);

    typedef logic [PTR_W-1:0] fifo_ptr_t;

    localparam fifo_ptr_t PTR_ONE  = fifo_ptr_t'(32'd1);
    localparam fifo_ptr_t THRESH_P = fifo_ptr_t'(AFULL_THRESH);

    fifo_ptr_t wr_ptr_r;
    fifo_ptr_t rd_ptr_r;
    fifo_ptr_t count_s;
    logic      full_s;
    logic      empty_s;
    logic      afull_s;
    logic      push_s;
    logic      pop_s;
    logic      wr_en_s;

    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign full_s  = (wr_ptr_r[ADDR_WIDTH] != rd_ptr_r[ADDR_WIDTH]) &&
                     (wr_ptr_r[ADDR_WIDTH-1:0] == rd_ptr_r[ADDR_WIDTH-1:0]);
    assign count_s = wr_ptr_r - rd_ptr_r;
    assign afull_s = (count_s >= THRESH_P);

    assign push_s  = s_valid & ~full_s;
    assign pop_s   = m_ready & ~empty_s;
    // A push dropped by flush must not disturb the stored words either.
    assign wr_en_s = push_s & ~flush;

    // Pointer registers: reset beats flush, flush beats both handshakes.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    sync_fifo_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .wr_en    (wr_en_s),
        .addr_in  (wr_ptr_r[ADDR_WIDTH-1:0]),
        .data_in  (s_data),
        .addr_out (rd_ptr_r[ADDR_WIDTH-1:0]),
        .data_out (m_data)
    );

    assign s_ready = ~full_s;
    assign m_valid = ~empty_s;
    assign count   = count_s;
    assign full    = full_s;
    assign empty   = empty_s;
    assign afull   = afull_s;

endmodule

// File: doc/sync_fifo_ctrl.md
# sync_fifo_ctrl

Synchronous first-word-fall-through FIFO controller for the Chien-search datapath. Accepts symbols from the upstream stage over a valid/ready handshake and stores them in a `sync_fifo_ram` instance. Presents the oldest entry to the downstream stage over a second valid/ready handshake. Tracks occupancy, full/empty and almost-full, and supports a synchronous flush between codewords.

## Interface
- `ADDR_WIDTH`, default 4: RAM address width; depth is `DEPTH = 1 << ADDR_WIDTH`.
- `DATA_WIDTH`, default 16: payload width.
- `AFULL_THRESH`, default `DEPTH-2`: `afull` asserts when `count >= AFULL_THRESH`; legal range is 1..`DEPTH`.
- `aclk`, input, 1: clock; all logic is on the rising edge.
- `aresetn`, input, 1: reset; synchronous, active-low.
- `flush`, input, 1: synchronous clear of pointers and count.
- `s_valid`, input, 1: upstream data valid.
- `s_ready`, output, 1: FIFO can accept; equals `!full`.
- `s_data`, input, `DATA_WIDTH`: upstream payload.
- `m_valid`, output, 1: head entry valid; equals `!empty`.
- `m_ready`, input, 1: downstream accepts the head entry.
- `m_data`, output, `DATA_WIDTH`: head entry, read combinationally from the RAM at `rd_ptr`.
- `count`, output, `ADDR_WIDTH+1`: current occupancy, 0..`DEPTH`.
- `full`, output, 1: `count == DEPTH`.
- `empty`, output, 1: `count == 0`.
- `afull`, output, 1: almost-full flag.

## Operation
- Events:
  - `push = s_valid & s_ready`.
  - `pop = m_valid & m_ready`.
- Pointers:
  - `wr_ptr` and `rd_ptr` are `ADDR_WIDTH+1` bits; the MSB is the wrap bit.
  - The low `ADDR_WIDTH` bits address the RAM.
  - Increment is modulo `2*DEPTH`, with natural wrap of the extra bit.
- Status decode:
  - `empty = (wr_ptr == rd_ptr)`.
  - `full = (wr_ptr[MSB] != rd_ptr[MSB]) && (low bits equal)`.
  - `count = wr_ptr - rd_ptr`, computed modulo `2*DEPTH`. It is combinational from the pointers; no separate counter.
- RAM hookup: `wr_en = push`, `addr_in = wr_ptr[ADDR_WIDTH-1:0]`, `data_in = s_data`, `addr_out = rd_ptr[ADDR_WIDTH-1:0]`.
- Push only: `wr_ptr` increments and `count` rises by 1.
- Pop only: `rd_ptr` increments and `count` falls by 1.
- Push and pop in the same cycle: both pointers increment and `count` is unchanged.
  - Legal only when not empty and not full, since `s_ready` and `m_valid` gate the events.
- Full: `s_ready = 0`, so no write and no pass-through. A pop in that cycle makes `s_ready = 1` in the next cycle.
- Empty: `m_valid = 0`; no bypass of `s_data` to `m_data`.
- Flush (`flush = 1` with `aresetn = 1`):
  - Next edge: `wr_ptr = rd_ptr = 0`, and push and pop in that cycle are ignored.
  - RAM contents are left untouched.
  - Flush has priority over push and pop.
- Reset has priority over flush. `aresetn = 0` at an edge sets both pointers to 0, regardless of any in-flight handshake.

## Timing
- Reset values:
  - `s_ready = 1`, `m_valid = 0`, `empty = 1`, `full = 0`, `count = 0`.
  - `afull = 0`, because `AFULL_THRESH >= 1`.
  - `m_data` is the RAM word at address 0 (don't-care while `m_valid = 0`).
- Write-to-read latency is 1 cycle. A word pushed at edge N has `m_valid = 1` and is on `m_data` after edge N.
- `m_data` changes only after a pop or a push into an empty FIFO. It is stable while `m_valid & !m_ready`.
- `s_ready`, `m_valid`, `full`, `empty`, `count` and `afull` are combinational from registered pointers only. There is no combinational path from `s_valid` or `m_ready` to any output.
- Sustained throughput is 1 word per cycle with both sides active.
- Mid-operation reset or flush: the first cycle after release behaves as a fresh empty FIFO.

## Structure
- Shared package `fifo_pkg`:
  - `localparam` helpers for `DEPTH` and pointer width.
  - typedef `fifo_ptr_t`, `logic [ADDR_WIDTH:0]`, parameterised by package function or per-instance typedef.
- One sub-module: `sync_fifo_ram`, with the same `ADDR_WIDTH` and `DATA_WIDTH`, driven as above.
  - Its reset input is tied to `aresetn`.
  - The controller depends on no RAM reset value.
- Controller RTL: pointer registers, status decode and handshake gating, about 150 lines.

## Test plan
- Reset and idle: hold `aresetn = 0` for 3 cycles, then release with no traffic. Expect `count = 0`, `empty = 1`, `s_ready = 1`, `m_valid = 0`, `afull = 0`.
- Fill to full: push 0x0001..0x0010 with `m_ready = 0` (DEPTH = 16). Expect `afull` after the 14th push and `full = 1`, `s_ready = 0`, `count = 16` after the 16th. A 17th `s_valid` is not written. Drain and expect 0x0001..0x0010 in order, ending with `empty = 1`.
- Wrap-around: run 40 pushes and 40 pops, interleaved with random gaps and occupancy ≤ 5. Expect data order preserved across 2+ pointer wraps and `count` matching a scoreboard every cycle.
- Simultaneous push and pop: at `count = 7`, assert `s_valid` and `m_ready` for 10 cycles. Expect `count = 7` throughout and 10 words out in order.
- Full with pop: at `count = 16`, pop one word. Expect `s_ready = 1` the next cycle; a push then restores `count = 16`.
- Flush and reset mid-stream: at `count = 9`, assert `flush` together with `s_valid`. Expect `count = 0` and `empty = 1` next cycle, with the pushed word dropped. Repeat using `aresetn = 0`; same result.
